// File: rtl/seqdet_rr_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// seqdet_pkg
//   Shared types and helpers for the round-robin "110" sequence-detector
//   scheduler: detector state encoding, default sizing constants, and the
//   next-state/detect function applied to whichever stream is granted.
//   The file is named after the block; the package keeps the name seqdet_pkg.
// ----------------------------------------------------------------------------
package seqdet_pkg;

    localparam int unsigned DEF_NCH = 4;
    localparam int unsigned DEF_CW  = 4;

    // 2'b11 is not a legal state; det_next() steers it back to S0.
    typedef enum logic [1:0] {
        S0  = 2'b00,
        S1  = 2'b01,
        S11 = 2'b10
    } det_state_e;

    typedef struct packed {
        det_state_e state;
        logic       detect;
    } det_step_t;

    // One Mealy step of the "110" detector on the consumed bit b.
    // The current state is taken as raw bits so an illegal code is visible.
    function automatic det_step_t det_next(input logic [1:0] cur, input logic b);
        det_step_t r;
        r.state  = S0;
        r.detect = 1'b0;
        case (cur)
            2'b00:   r.state = b ? S1 : S0;
            2'b01:   r.state = b ? S11 : S0;
            2'b10: begin
                if (b) begin
                    r.state = S11;
                end else begin
                    r.state  = S0;
                    r.detect = 1'b1;
                end
            end
            default: r.state = S0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seqdet_rr_scheduler_if.sv
// ----------------------------------------------------------------------------
// seqdet_rr_scheduler_if
//   Bundles the stream request/data, grant, detect and counter readout/clear
//   signals of seqdet_rr_scheduler.
//   master : stream front-ends + readout logic (drive req, bit_in, cnt_sel, clr)
//   slave  : the scheduler (drives gnt, z, z_ch, cnt_out)
// ----------------------------------------------------------------------------
interface seqdet_rr_scheduler_if
    import seqdet_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    parameter int unsigned CW  = DEF_CW
);
    localparam int unsigned CHW = $clog2(NCH);

    logic [NCH-1:0] req;
    logic [NCH-1:0] bit_in;
    logic [NCH-1:0] gnt;
    logic           z;
    logic [CHW-1:0] z_ch;
    logic [CHW-1:0] cnt_sel;
    logic [CW-1:0]  cnt_out;
    logic           clr;

    modport master (
        output req, bit_in, cnt_sel, clr,
        input  gnt, z, z_ch, cnt_out
    );

    modport slave (
        input  req, bit_in, cnt_sel, clr,
        output gnt, z, z_ch, cnt_out
    );

endinterface

// File: rtl/seqdet_rr_arb.sv
// ----------------------------------------------------------------------------
// seqdet_rr_arb
//   Round-robin arbiter with a registered rotating pointer. The search starts
//   at the pointer and wraps modulo NCH; the first requester is granted and
//   the pointer moves to the slot after it. With no request the pointer holds.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     req         : per-stream request
//     gnt         : one-hot grant (combinational), forced to 0 during reset
//     gnt_idx     : index of the granted stream
//     gnt_vld     : a grant is issued this cycle
// ----------------------------------------------------------------------------
module seqdet_rr_arb
    import seqdet_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req,
    output logic [NCH-1:0]          gnt,
    output logic [$clog2(NCH)-1:0]  gnt_idx,
    output logic                    gnt_vld
);
    localparam int unsigned CHW = $clog2(NCH);

    logic [CHW-1:0] ptr_q, ptr_d;
    int unsigned    cand;
    logic [CHW-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_vld  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NCH; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            cand_idx = cand[CHW-1:0];
            if (!gnt_vld && !reset && req[cand_idx]) begin
                gnt_vld       = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seqdet_rr_scheduler.sv
// ----------------------------------------------------------------------------
// seqdet_rr_scheduler
//   Time-shares one "110" detector datapath across NCH serial streams. A
//   round-robin arbiter grants one stream per cycle; the granted stream's bit
//   advances its own detector state and, on a detect, its own counter, so
//   switching between streams loses nothing.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     bus (slave) : req/bit_in in, gnt out, registered z/z_ch detect pulse,
//                   cnt_sel/clr in, combinational cnt_out readout
//   Build option:
//     SEQDET_CNT_SAT_EN  defined -> counters saturate at 2^CW-1
//                        undefined -> counters wrap modulo 2^CW
// ----------------------------------------------------------------------------
module seqdet_rr_scheduler
    import seqdet_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    parameter int unsigned CW  = DEF_CW
) (
    input  logic                   clk,
    input  logic                   reset,
    seqdet_rr_scheduler_if.slave   bus
);
    localparam int unsigned CHW = $clog2(NCH);

    logic [NCH-1:0] gnt_w;
    logic [CHW-1:0] gnt_idx;
    logic           gnt_vld;

    det_state_e     st_q  [NCH];
    det_state_e     st_d  [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic           z_q, z_d;
    logic [CHW-1:0] z_ch_q, z_ch_d;
    logic [CW-1:0]  cnt_out_w;
    det_step_t      step;

    seqdet_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req),
        .gnt     (gnt_w),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
`ifdef SEQDET_CNT_SAT_EN
        return (c == '1) ? c : c + CW'(1);
`else
        return c + CW'(1);
`endif
    endfunction

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        z_d    = 1'b0;
        z_ch_d = z_ch_q;
        step   = det_next(st_q[gnt_idx], bus.bit_in[gnt_idx]);
        if (gnt_vld) begin
            st_d[gnt_idx] = step.state;
            if (step.detect) begin
                z_d            = 1'b1;
                z_ch_d         = gnt_idx;
                cnt_d[gnt_idx] = cnt_inc(cnt_q[gnt_idx]);
            end
        end
        // Clear is applied after the increment so it wins on a shared counter;
        // a cnt_sel beyond NCH-1 matches no slot and is ignored.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.clr && (bus.cnt_sel == CHW'(i))) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        cnt_out_w = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.cnt_sel == CHW'(i)) begin
                cnt_out_w = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                st_q[i]  <= S0;
                cnt_q[i] <= '0;
            end
            z_q    <= 1'b0;
            z_ch_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            z_q    <= z_d;
            z_ch_q <= z_ch_d;
        end
    end

    assign bus.gnt     = gnt_w;
    assign bus.z       = z_q;
    assign bus.z_ch    = z_ch_q;
    assign bus.cnt_out = cnt_out_w;

endmodule

// File: tb/tb_seqdet_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_seqdet_rr_scheduler
//   Directed vectors with hand-computed expectations for the 4-stream,
//   4-bit-counter configuration, followed by hand sequences for counter
//   overflow and reset mid-pattern.
// ----------------------------------------------------------------------------
module tb_seqdet_rr_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 4;

    logic clk;
    logic reset;

    seqdet_rr_scheduler_if #(.NCH(NCH), .CW(CW)) bus ();

    seqdet_rr_scheduler #(.NCH(NCH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] bits;
        logic [1:0] sel;
        logic       clr;
        logic [3:0] gnt;
        logic       z;
        logic [1:0] zch;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   vectors;
    int   miscompares;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] bits,
                                input logic [1:0] sel, input logic clr,
                                input logic [3:0] gnt, input logic z,
                                input logic [1:0] zch, input logic [3:0] cnt);
        vec_t v;
        v.req = req; v.bits = bits; v.sel = sel; v.clr = clr;
        v.gnt = gnt; v.z = z; v.zch = zch; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, check gnt mid-cycle, check registered outputs after edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.req     = v.req;
        bus.bit_in  = v.bits;
        bus.cnt_sel = v.sel;
        bus.clr     = v.clr;
        #1;
        check({tag, ".gnt"}, int'(bus.gnt), int'(v.gnt));
        @(posedge clk);
        #1;
        check({tag, ".z"},    int'(bus.z),       int'(v.z));
        check({tag, ".z_ch"}, int'(bus.z_ch),    int'(v.zch));
        check({tag, ".cnt"},  int'(bus.cnt_out), int'(v.cnt));
        vectors++;
    endtask

    int exp_cnt;

    initial begin
        vectors     = 0;
        miscompares = 0;

        // ch0 alone: 1,1,0
        vecs.push_back(mk(4'h1, 4'h1, 2'd0, 1'b0, 4'h1, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'h1, 4'h1, 2'd0, 1'b0, 4'h1, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'h1, 4'h0, 2'd0, 1'b0, 4'h1, 1'b1, 2'd0, 4'd1));
        vecs.push_back(mk(4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd1));
        // all request, pointer at 1; ch2 feeds 1,1,0 across context switches
        vecs.push_back(mk(4'hF, 4'h4, 2'd2, 1'b0, 4'h2, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h4, 2'd2, 1'b0, 4'h4, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h4, 2'd2, 1'b0, 4'h8, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h4, 2'd2, 1'b0, 4'h1, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h4, 2'd2, 1'b0, 4'h2, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h4, 2'd2, 1'b0, 4'h4, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h0, 2'd2, 1'b0, 4'h8, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h0, 2'd2, 1'b0, 4'h1, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h0, 2'd2, 1'b0, 4'h2, 1'b0, 2'd0, 4'd0));
        vecs.push_back(mk(4'hF, 4'h0, 2'd2, 1'b0, 4'h4, 1'b1, 2'd2, 4'd1));
        vecs.push_back(mk(4'h0, 4'h0, 2'd2, 1'b0, 4'h0, 1'b0, 2'd2, 4'd1));
        vecs.push_back(mk(4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 2'd2, 4'd1));
        vecs.push_back(mk(4'h0, 4'h0, 2'd1, 1'b0, 4'h0, 1'b0, 2'd2, 4'd0));
        vecs.push_back(mk(4'h0, 4'h0, 2'd3, 1'b0, 4'h0, 1'b0, 2'd2, 4'd0));
        // ch1: "110110" then "1110"
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd2, 4'd0));
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd2, 4'd0));
        vecs.push_back(mk(4'h2, 4'h0, 2'd1, 1'b0, 4'h2, 1'b1, 2'd1, 4'd1));
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd1, 4'd1));
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd1, 4'd1));
        vecs.push_back(mk(4'h2, 4'h0, 2'd1, 1'b0, 4'h2, 1'b1, 2'd1, 4'd2));
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd1, 4'd2));
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd1, 4'd2));
        vecs.push_back(mk(4'h2, 4'h2, 2'd1, 1'b0, 4'h2, 1'b0, 2'd1, 4'd2));
        vecs.push_back(mk(4'h2, 4'h0, 2'd1, 1'b0, 4'h2, 1'b1, 2'd1, 4'd3));
        // ch3 detect with clr on the same counter: clr wins, z still pulses
        vecs.push_back(mk(4'h8, 4'h8, 2'd3, 1'b0, 4'h8, 1'b0, 2'd1, 4'd0));
        vecs.push_back(mk(4'h8, 4'h8, 2'd3, 1'b0, 4'h8, 1'b0, 2'd1, 4'd0));
        vecs.push_back(mk(4'h8, 4'h0, 2'd3, 1'b1, 4'h8, 1'b1, 2'd3, 4'd0));
        // ch3 detect with clr on ch0: both take effect
        vecs.push_back(mk(4'h8, 4'h8, 2'd0, 1'b0, 4'h8, 1'b0, 2'd3, 4'd1));
        vecs.push_back(mk(4'h8, 4'h8, 2'd0, 1'b0, 4'h8, 1'b0, 2'd3, 4'd1));
        vecs.push_back(mk(4'h8, 4'h0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'd0));
        vecs.push_back(mk(4'h0, 4'h0, 2'd3, 1'b0, 4'h0, 1'b0, 2'd3, 4'd1));

        // Reset with all streams requesting: gnt must stay 0.
        reset       = 1'b1;
        bus.req     = 4'hF;
        bus.bit_in  = 4'h0;
        bus.cnt_sel = 2'd0;
        bus.clr     = 1'b0;
        #2;
        check("rst.gnt", int'(bus.gnt), 0);
        check("rst.z",   int'(bus.z),   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.req = 4'h0;
        reset   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(mk(4'h0, 4'h0, 2'(i), 1'b0, 4'h0, 1'b0, 2'd0, 4'd0), "idle");
        end

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Sixteen detects on ch0 (counter starts at 0 after the clear above).
        exp_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            apply(mk(4'h1, 4'h1, 2'd0, 1'b0, 4'h1, 1'b0, 2'd3 - 2'(n == 0 ? 0 : 3), 4'(exp_cnt)), "ovf1a");
            apply(mk(4'h1, 4'h1, 2'd0, 1'b0, 4'h1, 1'b0, 2'd0 + 2'(n == 0 ? 3 : 0), 4'(exp_cnt)), "ovf1b");
`ifdef SEQDET_CNT_SAT_EN
            if (exp_cnt < 15) exp_cnt++;
`else
            exp_cnt = (exp_cnt + 1) % 16;
`endif
            apply(mk(4'h1, 4'h0, 2'd0, 1'b0, 4'h1, 1'b1, 2'd0, 4'(exp_cnt)), "ovf0");
        end
`ifdef SEQDET_CNT_SAT_EN
        check("ovf.final", int'(bus.cnt_out), 15);
`else
        check("ovf.final", int'(bus.cnt_out), 0);
`endif

        // Reset after "11": the following "0" must not detect.
        apply(mk(4'h1, 4'h1, 2'd0, 1'b0, 4'h1, 1'b0, 2'd0, 4'(exp_cnt)), "mid1");
        apply(mk(4'h1, 4'h1, 2'd0, 1'b0, 4'h1, 1'b0, 2'd0, 4'(exp_cnt)), "mid2");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid.rst.gnt", int'(bus.gnt),     0);
        check("mid.rst.cnt", int'(bus.cnt_out), 0);
        check("mid.rst.zch", int'(bus.z_ch),    0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(4'h1, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0, 2'd0, 4'd0), "mid0");
        apply(mk(4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0), "midend");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
